// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared types and constants for the instruction loader
//
// Contents:
//   state_e     loader FSM states (IDLE / LOAD / DONE)
//   TERMINATOR  assembled word that ends a program load
//   NOP         word returned to fetch while a load is in progress
package inst_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] TERMINATOR = 32'hffff_ffff;
    localparam logic [31:0] NOP        = 32'h0000_0000;

endpackage

// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - byte stream and fetch port bundle for the instruction loader
//
// Signals:
//   rx_valid   byte strobe from the UART receiver
//   rx_data    program byte, big-endian within each word
//   inst_addr  fetch word address
//   inst_data  instruction word returned to fetch
// Modports:
//   master  UART receiver + fetch stage side
//   slave   loader side
interface inst_loader_if #(
    parameter int ADDR_W = 17
) ();

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst_data;

    modport master (
        output rx_valid,
        output rx_data,
        output inst_addr,
        input  inst_data
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  inst_addr,
        output inst_data
    );

endinterface

// File: rtl/inst_bram.sv
// rtl/inst_bram.sv - simple dual-port instruction RAM, one write port, one registered read port
//
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write word address
//   wdata  write data
//   raddr  read word address
//   rdata  read data, registered (valid one cycle after raddr)
// A read and write to the same address on the same edge returns the old word.
// Neither the array nor the read register is reset so the RAM maps onto block RAM.
module inst_bram #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - program loader and instruction-memory responder
//
// Ports:
//   clk         clock
//   rstn        synchronous active-low reset
//   load_start  pulse: begin (or restart) a load at word 0
//   loading     high while in LOAD
//   load_done   high while in DONE
//   overflow    last load stopped because the RAM filled before the terminator
//   word_count  words written in the current or last load
//   bus         slave side of the byte stream and fetch port
// Bytes are assembled big-endian into 32-bit words and written from word 0 up.
// Fetch reads return RAM data one cycle after the address, or NOP during a load.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_start,
    output logic              loading,
    output logic              load_done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    inst_loader_if.slave      bus
);

    state_e            state_q,   state_d;
    logic [1:0]        bcnt_q,    bcnt_d;
    logic [23:0]       asm_q,     asm_d;
    logic [ADDR_W-1:0] wptr_q,    wptr_d;
    logic [ADDR_W:0]   wcnt_q,    wcnt_d;
    logic              ovf_q,     ovf_d;
    logic              loading_q, loading_d;
    logic              done_q,    done_d;
    logic              nop_sel_q, nop_sel_d;

    logic              ram_we;
    logic [31:0]       full_word;
    logic [31:0]       ram_rdata;

    // Only the first three bytes are held; the fourth is taken straight from
    // the stream on the edge that writes the word.
    assign full_word = {asm_q, bus.rx_data};

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        wptr_d    = wptr_q;
        wcnt_d    = wcnt_q;
        ovf_d     = ovf_q;
        ram_we    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    bcnt_d  = 2'd0;
                    wptr_d  = '0;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.rx_valid) begin
                    bcnt_d = bcnt_q + 2'd1;
                    asm_d  = {asm_q[15:0], bus.rx_data};
                    if (bcnt_q == 2'd3) begin
                        ram_we = 1'b1;
                        wptr_d = wptr_q + ADDR_W'(1);
                        wcnt_d = wcnt_q + (ADDR_W+1)'(1);
                        if (full_word == TERMINATOR) begin
                            state_d = ST_DONE;
                        end else if (wptr_q == '1) begin
                            // Last RAM word written without a terminator.
                            state_d = ST_DONE;
                            ovf_d   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        loading_d = (state_d == ST_LOAD);
        done_d    = (state_d == ST_DONE);
        // The read register holds RAM data for the address of this cycle, so
        // the NOP override must follow the state of this cycle too.
        nop_sel_d = (state_q == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            bcnt_q    <= 2'd0;
            asm_q     <= '0;
            wptr_q    <= '0;
            wcnt_q    <= '0;
            ovf_q     <= 1'b0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            nop_sel_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            asm_q     <= asm_d;
            wptr_q    <= wptr_d;
            wcnt_q    <= wcnt_d;
            ovf_q     <= ovf_d;
            loading_q <= loading_d;
            done_q    <= done_d;
            nop_sel_q <= nop_sel_d;
        end
    end

    inst_bram #(
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata (full_word),
        .raddr (bus.inst_addr),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset, so a registered select masks it
    // after reset and during a load.
    assign bus.inst_data = nop_sel_q ? NOP : ram_rdata;

    assign loading    = loading_q;
    assign load_done  = done_q;
    assign overflow   = ovf_q;
    assign word_count = wcnt_q;

endmodule

// File: doc/inst_loader.md
# inst_loader

Instruction-memory responder and program loader for the core. It receives the program as a big-endian byte stream from the UART receiver and assembles it into 32-bit words. It writes those words into an internal instruction RAM starting at word 0. Once loading completes, it serves the fetch stage's instruction read port (`inst_addr` → `inst_data`) with one cycle of registered latency.

## Interface
Parameters:
- `ADDR_W`, default 17: word-address width; RAM depth is 2**`ADDR_W` words.

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-low
- `load_start`  in  1  single-cycle pulse that begins a load at word 0
- `rx_valid`  in  1  `rx_data` holds a new byte this cycle
- `rx_data`  in  8  program byte
- `loading`  out  1  high in state LOAD
- `load_done`  out  1  high in state DONE
- `overflow`  out  1  load ended because RAM filled before the terminator arrived
- `word_count`  out  `ADDR_W`+1  number of words written in the current or last load
- `inst_addr`  in  `ADDR_W`  fetch word address
- `inst_data`  out  32  instruction word

## Operation
- FSM with three states: IDLE, LOAD, DONE.
  - IDLE → LOAD on `load_start`.
  - LOAD → DONE on terminator word or overflow.
  - DONE → LOAD on `load_start`, which restarts the load.
- Entering LOAD clears the write pointer, the byte counter (0..3), `word_count` and `overflow`. RAM contents are not cleared.
- LOAD byte handling:
  - Each `rx_valid` byte shifts into the assembly register, first byte in bits [31:24].
  - On the 4th byte, the full word `{b0,b1,b2,b3}` is written to RAM[wptr]; wptr and `word_count` then increment.
- Terminator: an assembled word equal to 32'hffffffff is written like any other word and counted, then the FSM goes to DONE.
- Overflow: if a word is written at wptr = 2**`ADDR_W`−1 and it is not the terminator, the FSM goes to DONE with `overflow`=1. Further bytes are ignored.
- `rx_valid` in IDLE or DONE is ignored. `load_start` during LOAD is ignored.
- Read port:
  - `inst_data` is registered every cycle: `inst_data` ← RAM[`inst_addr`], except in state LOAD, where it is ← 32'h0 so the core sees NOPs.
  - Read-during-write to the same address returns the old data.
- Reset values:
  - state IDLE; `loading`=0, `load_done`=0, `overflow`=0, `word_count`=0; `inst_data`=0.
  - Byte counter and wptr are 0.
  - RAM is not initialised by reset.
- Reset mid-load: the FSM returns to IDLE and partial word bytes are discarded. Words already written stay in RAM.

## Timing
- Byte acceptance: a byte is accepted on the rising edge where `rx_valid`=1. There is no backpressure, and back-to-back bytes on consecutive cycles must be accepted.
- Word write: the RAM write, the wptr increment and the `word_count` update all happen on the edge accepting the 4th byte. The new `word_count` is visible after that edge.
- End of load:
  - `load_done` (and `overflow` when applicable) rise after the edge that writes the final word, and `loading` falls on that same edge.
  - A read of that final word is valid from the next cycle.
- Read latency: `inst_addr` presented before edge N gives the matching `inst_data` after edge N (1 cycle). Fetch drives its address combinationally and samples on the following negedge, so this fits.
- `load_start`: a `load_start` pulse seen at edge N sets `loading` after edge N. A byte presented in that same cycle is ignored.

## Structure
- Shared package `inst_loader_pkg`:
  - state enum (IDLE/LOAD/DONE);
  - `TERMINATOR` = 32'hffffffff;
  - `NOP` = 32'h0.
- Sub-module `inst_bram`: simple dual-port RAM with one synchronous write port, one registered read port and parameter `ADDR_W`. It must be inferable as block RAM.
- The FSM, byte assembly and read-data muxing stay in `inst_loader`.

## Test plan
- Basic load: reset, `load_start`, then bytes 00 11 22 33 / 44 55 66 77 / ff ff ff ff back-to-back → RAM[0]=32'h00112233, RAM[1]=32'h44556677, RAM[2]=32'hffffffff; `word_count`=3; `load_done`=1 one cycle after the last byte.
- Read latency: after DONE, drive `inst_addr`=0,1,2 on consecutive cycles → `inst_data` = 00112233, 44556677, ffffffff, each one cycle later. During LOAD, any `inst_addr` → `inst_data`=0.
- Gapped stream: bytes separated by random 0–5 idle cycles, plus `rx_valid` pulses before `load_start` → identical RAM contents to the basic load. Pre-start bytes are ignored.
- Overflow: with `ADDR_W`=3, stream 9 non-terminator words → 8 words written, `overflow`=1, `load_done`=1, `word_count`=8. The 9th word is dropped.
- Reset mid-load: reset after 6 bytes → IDLE, `word_count`=0, RAM[0] keeps its word. A new load of 1 word + terminator then gives `word_count`=2 and RAM[0] = the new word.
- Reload from DONE: `load_start` in DONE → `loading`=1, `load_done`=0, `word_count`=0. A second program overwrites from word 0.
